// File: rtl/dmem_pkg.sv
// Shared address map and STATUS layout for the data-memory / MMIO block.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] TXDATA_OFS  = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS  = 32'h0000_0004;
  localparam logic [31:0] CYCLE_OFS   = 32'h0000_0008;

  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + STATUS_OFS;
  localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + CYCLE_OFS;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_COUNT_LSB = 2;
  localparam int unsigned ST_COUNT_W   = 5;
  localparam int unsigned ST_OVF       = 8;
  localparam int unsigned ST_ERR       = 9;

  typedef enum logic [2:0] {
    RegionRam,
    RegionTxData,
    RegionStatus,
    RegionCycle,
    RegionNone
  } regionT;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the transmit port; head byte reads as 0 while empty.
module tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? 8'h00 : mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped transmit FIFO, status and free-running cycle counter.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram [RAM_WORDS];
  regionT           region;
  logic [31:0]      statusWord;
  logic [31:0]      cycleCount;
  logic             ovfFlag;
  logic             errFlag;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic [7:0]       fifoDout;
  logic             ramWe;
  logic             txPush;
  logic             txPop;
  logic             statusWr;
  logic             cycleWr;
  logic             unmappedWr;
  logic             unusedAddrBits;

  assign unusedAddrBits = ^Addr[1:0];

  // Word-granular address decode.
  always_comb begin
    region = RegionNone;
    if (Addr[31:IDX_W+2] == '0)                        region = RegionRam;
    else if (Addr[31:2] == TXDATA_ADDR[31:2])          region = RegionTxData;
    else if (Addr[31:2] == STATUS_ADDR[31:2])          region = RegionStatus;
    else if (Addr[31:2] == CYCLE_ADDR[31:2])           region = RegionCycle;
  end

  assign ramWe      = MemWrite & (region == RegionRam);
  assign txPush     = MemWrite & (region == RegionTxData);
  assign statusWr   = MemWrite & (region == RegionStatus);
  assign cycleWr    = MemWrite & (region == RegionCycle);
  assign unmappedWr = MemWrite & (region == RegionNone);
  assign txPop      = tx_valid & tx_ready;

  always_comb begin
    statusWord                                = '0;
    statusWord[ST_FULL]                       = fifoFull;
    statusWord[ST_EMPTY]                      = fifoEmpty;
    statusWord[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifoCount);
    statusWord[ST_OVF]                        = ovfFlag;
    statusWord[ST_ERR]                        = errFlag;
  end

  // Loads are combinational so the core sees data in its memory stage.
  always_comb begin
    ReadData = '0;
    case (region)
      RegionRam:    ReadData = ram[Addr[IDX_W+1:2]];
      RegionStatus: ReadData = statusWord;
      RegionCycle:  ReadData = cycleCount;
      default:      ReadData = '0;
    endcase
  end

  // RAM survives reset by design.
  always_ff @(posedge clk) begin
    if (ramWe) ram[Addr[IDX_W+1:2]] <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= '0;
    end else if (cycleWr) begin
      cycleCount <= WriteData;
    end else begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  // Sticky flags: a STATUS write clears them, a same-cycle overflow still sets OVF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovfFlag <= 1'b0;
      errFlag <= 1'b0;
    end else begin
      if (txPush & fifoFull & ~txPop) ovfFlag <= 1'b1;
      else if (statusWr)              ovfFlag <= 1'b0;
      if (unmappedWr)                 errFlag <= 1'b1;
      else if (statusWr)              errFlag <= 1'b0;
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) uTxFifo (
    .clk   (clk),
    .reset (reset),
    .push  (txPush),
    .pop   (txPop),
    .din   (WriteData[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign tx_valid = ~fifoEmpty;
  assign tx_data  = fifoDout;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio with a queue-based reference model checked every cycle.
module tb_dmem_mmio;

  localparam int unsigned RAM_WORDS = 64;
  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] TX_A      = 32'h8000_0000;
  localparam logic [31:0] ST_A      = 32'h8000_0004;
  localparam logic [31:0] CY_A      = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        tx_ready = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int nCompared = 0;
  int nMismatched = 0;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mRam [RAM_WORDS];
  bit          mKnown [RAM_WORDS];
  logic [7:0]  mQ [$];
  bit          mOvf = 1'b0;
  bit          mErr = 1'b0;
  logic [31:0] mCycle = 32'h0;
  int          mRegion;
  bit          mPopNow;
  bit          mFullNow;

  // 0 RAM, 1 TXDATA, 2 STATUS, 3 CYCLE, 4 unmapped
  function automatic int regionOf(logic [31:0] a);
    if (a < 32'(4 * RAM_WORDS))     return 0;
    if ((a >> 2) == (TX_A >> 2))    return 1;
    if ((a >> 2) == (ST_A >> 2))    return 2;
    if ((a >> 2) == (CY_A >> 2))    return 3;
    return 4;
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] a);
    case (regionOf(a))
      0: return mRam[a >> 2];
      2: return {22'd0, mErr, mOvf, 1'b0, 5'(mQ.size()),
                 1'(mQ.size() == 0), 1'(mQ.size() == DEPTH)};
      3: return mCycle;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mQ.delete();
        mOvf = 1'b0;
        mErr = 1'b0;
        mCycle = 32'h0;
      end else begin
        mRegion  = regionOf(Addr);
        mPopNow  = (mQ.size() != 0) && tx_ready;
        mFullNow = (mQ.size() == DEPTH);
        mCycle   = (MemWrite && mRegion == 3) ? WriteData : mCycle + 32'd1;
        if (MemWrite && mRegion == 0) begin
          mRam[Addr >> 2]   = WriteData;
          mKnown[Addr >> 2] = 1'b1;
        end
        if (MemWrite && mRegion == 2) begin
          mOvf = 1'b0;
          mErr = 1'b0;
        end
        if (MemWrite && mRegion == 4) mErr = 1'b1;
        if (mPopNow) void'(mQ.pop_front());
        if (MemWrite && mRegion == 1) begin
          if (!mFullNow || mPopNow) mQ.push_back(WriteData[7:0]);
          else                       mOvf = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-way through the low phase.
  always @(negedge clk) begin
    #2;
    check("tx_valid", 32'(tx_valid), 32'(mQ.size() != 0));
    if (mQ.size() != 0) check("tx_data", 32'(tx_data), 32'(mQ[0]));
    else if (reset)     check("tx_data_rst", 32'(tx_data), 32'h0);
    if (regionOf(Addr) != 0 || mKnown[Addr >> 2])
      check("ReadData", ReadData, modelRead(Addr));
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    MemWrite  = we;
    Addr      = a;
    WriteData = d;
    tx_ready  = rdy;
  endtask

  logic [7:0] expOrder [4];

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    Addr  = ST_A;
    #3 check("lit_status_reset", ReadData, 32'h0000_0002);
    drive(0, CY_A, 0, 0);
    #3 check("lit_cycle_first", ReadData, 32'h0000_0001);

    // RAM store then asynchronous load
    drive(1, 32'h14, 32'h1111_1111, 0);
    drive(1, 32'h10, 32'hDEAD_BEEF, 0);
    drive(0, 32'h10, 0, 0);
    #3 check("lit_ram10", ReadData, 32'hDEAD_BEEF);
    drive(0, 32'h14, 0, 0);
    #3 check("lit_ram14", ReadData, 32'h1111_1111);

    // Overflow on fifth push, then ordered drain
    for (int i = 0; i < 5; i++) drive(1, TX_A, 32'(8'h41 + i), 0);
    drive(0, ST_A, 0, 0);
    #3 check("lit_status_ovf", ReadData, 32'h0000_0111);
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h10, 0, 1);
      #3 check("lit_drain", 32'(tx_data), 32'(8'h41 + i));
    end
    drive(0, 32'h10, 0, 0);
    #3 check("lit_empty", 32'(tx_valid), 32'h0);
    drive(1, ST_A, 0, 0);
    drive(0, ST_A, 0, 0);
    #3 check("lit_ovf_clr", ReadData, 32'h0000_0002);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) drive(1, TX_A, 32'(8'h50 + i), 0);
    drive(1, TX_A, 32'h55, 1);
    drive(0, ST_A, 0, 0);
    #3 check("lit_full_pushpop", ReadData, 32'h0000_0011);
    expOrder[0] = 8'h51; expOrder[1] = 8'h52; expOrder[2] = 8'h53; expOrder[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      drive(0, ST_A, 0, 1);
      #3 check("lit_full_order", 32'(tx_data), 32'(expOrder[i]));
    end

    // Push and pop together at count 1
    drive(1, TX_A, 32'h60, 0);
    drive(1, TX_A, 32'h61, 1);
    drive(0, ST_A, 0, 0);
    #3 check("lit_cnt1_status", ReadData, 32'h0000_0004);
    check("lit_cnt1_head", 32'(tx_data), 32'h61);
    drive(0, ST_A, 0, 1);
    drive(0, ST_A, 0, 0);

    // Cycle counter load and wrap
    drive(1, CY_A, 32'hFFFF_FFFE, 0);
    drive(0, CY_A, 0, 0);
    #3 check("lit_cyc_load", ReadData, 32'hFFFF_FFFE);
    drive(0, CY_A, 0, 0);
    #3 check("lit_cyc_max", ReadData, 32'hFFFF_FFFF);
    drive(0, CY_A, 0, 0);
    #3 check("lit_cyc_wrap", ReadData, 32'h0000_0000);

    // Unmapped write sets ERR only
    drive(1, 32'h4000_0000, 32'hCAFE_F00D, 0);
    drive(0, ST_A, 0, 0);
    #3 check("lit_err_set", ReadData, 32'h0000_0202);
    drive(0, 32'h10, 0, 0);
    #3 check("lit_err_ram", ReadData, 32'hDEAD_BEEF);
    drive(1, ST_A, 0, 0);
    drive(0, ST_A, 0, 0);
    #3 check("lit_err_clr", ReadData, 32'h0000_0002);

    // Reset mid-transfer
    drive(1, 32'h20, 32'h1234_5678, 0);
    for (int i = 0; i < 3; i++) drive(1, TX_A, 32'(8'h71 + i), 0);
    drive(0, ST_A, 0, 0);
    #3 reset = 1'b1;
    #1 check("lit_rst_valid", 32'(tx_valid), 32'h0);
    check("lit_rst_status", ReadData, 32'h0000_0002);
    check("lit_rst_data", 32'(tx_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    Addr  = 32'h20;
    #3 check("lit_rst_ram", ReadData, 32'h1234_5678);
    drive(0, CY_A, 0, 0);
    #3 check("lit_rst_cycle", ReadData, 32'h0000_0001);

    repeat (2) @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter RAM_WORDS, 64, number of 32-bit RAM words (power of two, 16..256).
REQ-002 Parameter FIFO_DEPTH, 4, transmit FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemWrite  input  1  store strobe from the core's memory stage.
REQ-006 Addr  input  32  byte address from the core's memory stage.
REQ-007 WriteData  input  32  store data.
REQ-008 ReadData  output  32  load data, combinational from Addr in the same cycle.
REQ-009 tx_data  output  8  byte at FIFO head.
REQ-010 tx_valid  output  1  FIFO non-empty.
REQ-011 tx_ready  input  1  consumer accepts head byte when tx_valid & tx_ready.

Function
REQ-012 Address map (word-aligned; Addr[1:0] ignored): RAM at 0x0000_0000..4*RAM_WORDS-1; TXDATA 0x8000_0000; STATUS 0x8000_0004; CYCLE 0x8000_0008; everything else unmapped.
REQ-013 RAM: write on the clock edge when MemWrite & RAM hit, indexed by Addr[log2(RAM_WORDS)+1:2]; read asynchronous.
REQ-014 Read data: RAM word, STATUS value, or CYCLE value per decode; TXDATA and unmapped read 0.
REQ-015 TXDATA write pushes WriteData[7:0] into the FIFO.
REQ-016 Pop occurs on the edge where tx_valid & tx_ready; tx_data/tx_valid are registered-state outputs (no combinational path from MemWrite or Addr).
REQ-017 Push while full without a simultaneous pop: byte dropped, FIFO unchanged, OVF sticky set.
REQ-018 Push and pop in the same cycle: both performed, count unchanged, including when full (no OVF) and when count=1.
REQ-019 Push while empty: tx_valid high the following cycle with tx_data = pushed byte (one-cycle latency).
REQ-020 FIFO pointers wrap modulo FIFO_DEPTH; FIFO order strictly preserved.
REQ-021 STATUS bits: [0] full, [1] empty, [6:2] count (0..FIFO_DEPTH), [8] OVF sticky, [9] ERR sticky; other bits 0.
REQ-022 Any write to STATUS clears OVF and ERR; if an overflow occurs in the same cycle, set wins.
REQ-023 Write or read-with-MemWrite to an unmapped address sets ERR; no other state changes.
REQ-024 CYCLE: 32-bit counter incrementing every cycle, 0xFFFF_FFFF wraps to 0.
REQ-025 CYCLE write loads WriteData; load takes priority over increment that cycle; increment resumes next cycle.

Reset
REQ-026 On reset assertion, immediately: FIFO empty (pointers, count 0), tx_valid=0, tx_data=0, OVF=0, ERR=0, CYCLE=0.
REQ-027 RAM contents are not reset and are not altered by reset.
REQ-028 Reset mid-transfer discards all queued bytes; first edge after deassertion counts CYCLE to 1.
REQ-029 ReadData remains combinational during reset (STATUS reads 0x0000_0002).

Structure
REQ-030 Shared package dmem_pkg holds the address constants (TXDATA, STATUS, CYCLE base/offsets) and STATUS bit positions.
REQ-031 FIFO is a separate sub-module tx_fifo (push, pop, din, dout, full, empty, count), instantiated once.
REQ-032 Decode, RAM, CYCLE counter and sticky flags reside in dmem_mmio.

Verification
REQ-033 Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 -> ReadData=0xDEADBEEF same cycle; read 0x0000_0014 unchanged.
REQ-034 tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x0000_0111 (full, count 4, OVF); release tx_ready -> bytes 0x41..0x44 in order, then empty.
REQ-035 FIFO full, push 0x55 with tx_ready=1 same cycle -> no OVF, count stays 4, 0x55 emerges last.
REQ-036 Write 0xFFFF_FFFE to CYCLE -> reads 0xFFFF_FFFF one cycle later, 0x0000_0000 two cycles later.
REQ-037 Write to 0x4000_0000 -> ERR=1, RAM/FIFO unchanged; write STATUS -> ERR=0.
REQ-038 Assert reset with 3 bytes queued -> tx_valid=0 immediately (before next edge), STATUS=0x2, RAM data retained.
